// File: rtl/pwm_duty_meter_if.sv
// PWM duty meter bundle: control/stimulus in, measurement results out.
// master drives en/pwm_in, slave (the meter) drives the results.
interface pwm_duty_meter_if #(
    parameter int CNT_W  = 16,
    parameter int DUTY_W = 8
);
    logic              en;
    logic              pwm_in;
    logic [CNT_W-1:0]  period_cnt;
    logic [CNT_W-1:0]  high_cnt;
    logic [DUTY_W-1:0] duty;
    logic              valid;
    logic              stuck_hi;
    logic              stuck_lo;

    modport master (
        output en, pwm_in,
        input  period_cnt, high_cnt, duty, valid, stuck_hi, stuck_lo
    );

    modport slave (
        input  en, pwm_in,
        output period_cnt, high_cnt, duty, valid, stuck_hi, stuck_lo
    );
endinterface

// File: rtl/pwm_duty_meter.sv
// PWM duty meter: measures period, high time and duty of a looped-back
// PWM line; flags a line stuck high or low.
module pwm_duty_meter #(
    parameter int CNT_W   = 16,
    parameter int DUTY_W  = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              rst,
    pwm_duty_meter_if.slave   bus
);

    localparam int BW = $clog2(DUTY_W);
    localparam logic [BW-1:0]    BIT_LAST = BW'(DUTY_W - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DIVIDE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic sync1_q, sync2_q, lvl_q, rise_q, fall_q;

    logic [CNT_W-1:0]  per_q, per_d;
    logic [CNT_W-1:0]  hi_q, hi_d;
    logic              run_q, run_d;
    logic [CNT_W-1:0]  cap_per_q, cap_per_d;
    logic [CNT_W-1:0]  cap_hi_q, cap_hi_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [DUTY_W-1:0] quo_q, quo_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  high_q, high_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              valid_q, valid_d;
    logic              stk_hi_q, stk_hi_d;
    logic              stk_lo_q, stk_lo_d;

    logic [CNT_W:0]    r2;
    logic              ge;
    logic              tmo;

    // Two-flop synchroniser followed by a registered edge detector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lvl_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= bus.pwm_in;
            sync2_q <= sync1_q;
            lvl_q   <= sync2_q;
            rise_q  <= sync2_q & ~lvl_q;
            fall_q  <= ~sync2_q & lvl_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, divider and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_q     <= '0;
            hi_q      <= '0;
            run_q     <= 1'b0;
            cap_per_q <= '0;
            cap_hi_q  <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            bit_q     <= '0;
            period_q  <= '0;
            high_q    <= '0;
            duty_q    <= '0;
            valid_q   <= 1'b0;
            stk_hi_q  <= 1'b0;
            stk_lo_q  <= 1'b0;
        end else begin
            per_q     <= per_d;
            hi_q      <= hi_d;
            run_q     <= run_d;
            cap_per_q <= cap_per_d;
            cap_hi_q  <= cap_hi_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            bit_q     <= bit_d;
            period_q  <= period_d;
            high_q    <= high_d;
            duty_q    <= duty_d;
            valid_q   <= valid_d;
            stk_hi_q  <= stk_hi_d;
            stk_lo_q  <= stk_lo_d;
        end
    end

    // Next state: edge-driven measurement, timeout and restoring divide
    always_comb begin
        state_d   = state_q;
        per_d     = per_q;
        hi_d      = hi_q;
        run_d     = run_q;
        cap_per_d = cap_per_q;
        cap_hi_d  = cap_hi_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        bit_d     = bit_q;
        period_d  = period_q;
        high_d    = high_q;
        duty_d    = duty_q;
        valid_d   = 1'b0;
        stk_hi_d  = stk_hi_q;
        stk_lo_d  = stk_lo_q;

        r2  = {rem_q, 1'b0};
        ge  = (r2 >= {1'b0, cap_per_q});
        tmo = (per_q == TMO_LAST);

        if (!bus.en) begin
            state_d  = IDLE;
            per_d    = '0;
            hi_d     = '0;
            run_d    = 1'b0;
            stk_hi_d = 1'b0;
            stk_lo_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rise_q) begin
                        state_d  = MEASURE;
                        per_d    = CNT_W'(1);
                        hi_d     = CNT_W'(1);
                        run_d    = 1'b1;
                        stk_hi_d = 1'b0;
                        stk_lo_d = 1'b0;
                    end else if (!stk_hi_q && !stk_lo_q) begin
                        // Line never toggled since enable: count towards stuck_lo
                        if (tmo) begin
                            stk_lo_d = 1'b1;
                            per_d    = '0;
                        end else begin
                            per_d = per_q + 1'b1;
                        end
                    end
                end
                MEASURE, DIVIDE: begin
                    if (rise_q) begin
                        per_d    = CNT_W'(1);
                        hi_d     = CNT_W'(1);
                        run_d    = 1'b1;
                        stk_hi_d = 1'b0;
                        stk_lo_d = 1'b0;
                        // A rise while dividing is dropped; only MEASURE captures
                        if (state_q == MEASURE) begin
                            state_d   = DIVIDE;
                            cap_per_d = per_q;
                            cap_hi_d  = hi_q;
                            rem_d     = hi_q;
                            quo_d     = '0;
                            bit_d     = '0;
                        end
                    end else if (tmo) begin
                        state_d = IDLE;
                        per_d   = '0;
                        hi_d    = '0;
                        run_d   = 1'b0;
                        if (lvl_q) begin
                            stk_hi_d = 1'b1;
                        end else begin
                            stk_lo_d = 1'b1;
                        end
                    end else begin
                        per_d = per_q + 1'b1;
                        if (run_q) begin
                            if (fall_q) begin
                                run_d = 1'b0;
                            end else begin
                                hi_d = hi_q + 1'b1;
                            end
                        end
                    end
                    // One quotient bit per cycle; a timeout aborts the divide
                    if (state_q == DIVIDE && (rise_q || !tmo)) begin
                        rem_d = ge ? CNT_W'(r2 - {1'b0, cap_per_q})
                                   : CNT_W'(r2);
                        quo_d = {quo_q[DUTY_W-2:0], ge};
                        bit_d = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
                            state_d  = MEASURE;
                            period_d = cap_per_q;
                            high_d   = cap_hi_q;
                            duty_d   = {quo_q[DUTY_W-2:0], ge};
                            valid_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.period_cnt = period_q;
    assign bus.high_cnt   = high_q;
    assign bus.duty       = duty_q;
    assign bus.valid      = valid_q;
    assign bus.stuck_hi   = stk_hi_q;
    assign bus.stuck_lo   = stk_lo_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter: table of PWM shapes with hand-computed
// results, plus sequences for divide overlap, timeouts, reset and enable.
module tb_pwm_duty_meter;

    localparam int CNT_W   = 16;
    localparam int DUTY_W  = 8;
    localparam int TIMEOUT = 4000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pwm_duty_meter_if #(.CNT_W(CNT_W), .DUTY_W(DUTY_W)) bus ();

    pwm_duty_meter #(
        .CNT_W  (CNT_W),
        .DUTY_W (DUTY_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int per;
        int hi;
        int duty;
    } vec_t;

    int errs   = 0;
    int checks = 0;
    int vcount = 0;
    int cyc_n  = 0;
    int t_last = 0;
    int t_prev = 0;

    // Valid pulse monitor, sampled away from the active edge
    always @(negedge clk) begin
        cyc_n++;
        if (bus.valid === 1'b1) begin
            vcount++;
            t_prev = t_last;
            t_last = cyc_n;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_period(input int p, input int h);
        bus.pwm_in = 1'b1;
        cyc(h);
        bus.pwm_in = 1'b0;
        cyc(p - h);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus.en     = 1'b0;
        bus.pwm_in = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, " period"}, 32'(bus.period_cnt), 0);
        check({tag, " high"}, 32'(bus.high_cnt), 0);
        check({tag, " duty"}, 32'(bus.duty), 0);
    endtask

    vec_t vecs[8];
    int   v0;

    initial begin
        vecs[0] = '{per: 100,  hi: 25,   duty: 64};
        vecs[1] = '{per: 30,   hi: 10,   duty: 85};
        vecs[2] = '{per: 3000, hi: 2999, duty: 255};
        vecs[3] = '{per: 10,   hi: 1,    duty: 25};
        vecs[4] = '{per: 255,  hi: 128,  duty: 128};
        vecs[5] = '{per: 200,  hi: 199,  duty: 254};
        vecs[6] = '{per: 17,   hi: 5,    duty: 75};
        vecs[7] = '{per: 9,    hi: 4,    duty: 113};

        bus.en     = 1'b0;
        bus.pwm_in = 1'b0;
        #1;
        check_outs_zero("reset");
        check("reset valid", 32'(bus.valid), 0);
        check("reset stuck", 32'({bus.stuck_hi, bus.stuck_lo}), 0);
        do_reset();

        // Table: four PWM periods each, three captures expected
        for (int i = 0; i < 8; i++) begin
            bus.en = 1'b0;
            cyc(3);
            bus.en = 1'b1;
            v0 = vcount;
            repeat (4) drive_period(vecs[i].per, vecs[i].hi);
            cyc(15);
            check($sformatf("v%0d valids", i), 32'(vcount - v0), 3);
            check($sformatf("v%0d period", i), 32'(bus.period_cnt),
                  32'(vecs[i].per));
            check($sformatf("v%0d high", i), 32'(bus.high_cnt),
                  32'(vecs[i].hi));
            check($sformatf("v%0d duty", i), 32'(bus.duty),
                  32'(vecs[i].duty));
            check($sformatf("v%0d stuck", i),
                  32'({bus.stuck_hi, bus.stuck_lo}), 0);
        end

        // Period shorter than the divide: every other rise is dropped
        bus.en = 1'b0;
        cyc(3);
        bus.en = 1'b1;
        v0 = vcount;
        repeat (6) drive_period(6, 3);
        cyc(15);
        check("short valids", 32'(vcount - v0), 3);
        check("short spacing", 32'(t_last - t_prev), 12);
        check("short period", 32'(bus.period_cnt), 6);
        check("short high", 32'(bus.high_cnt), 3);
        check("short duty", 32'(bus.duty), 128);

        // Reset asserted in the middle of a divide
        do_reset();
        bus.en = 1'b1;
        repeat (2) drive_period(100, 25);
        check("pre-rst duty", 32'(bus.duty), 64);
        bus.pwm_in = 1'b1;
        cyc(6);
        v0 = vcount;
        rst = 1'b1;
        #1;
        check_outs_zero("rst mid-div");
        cyc(2);
        rst = 1'b0;
        cyc(20);
        check("rst mid-div valids", 32'(vcount - v0), 0);
        check_outs_zero("rst after");

        // Never toggling line: stuck_lo after exactly TIMEOUT cycles
        do_reset();
        v0 = vcount;
        bus.en = 1'b1;
        cyc(TIMEOUT - 1);
        check("stuck_lo early", 32'(bus.stuck_lo), 0);
        cyc(1);
        check("stuck_lo set", 32'(bus.stuck_lo), 1);
        check("stuck_lo hi flag", 32'(bus.stuck_hi), 0);
        check("stuck_lo valids", 32'(vcount - v0), 0);
        check_outs_zero("stuck_lo");

        // Line held high after one rise: stuck_hi TIMEOUT after the pulse
        do_reset();
        v0 = vcount;
        bus.en     = 1'b1;
        bus.pwm_in = 1'b1;
        cyc(3 + TIMEOUT - 1);
        check("stuck_hi early", 32'(bus.stuck_hi), 0);
        cyc(1);
        check("stuck_hi set", 32'(bus.stuck_hi), 1);
        check("stuck_hi lo flag", 32'(bus.stuck_lo), 0);
        check("stuck_hi valids", 32'(vcount - v0), 0);
        bus.pwm_in = 1'b0;
        cyc(50);
        check("stuck_hi after fall", 32'(bus.stuck_hi), 1);
        bus.pwm_in = 1'b1;
        cyc(3);
        check("stuck_hi at rise", 32'(bus.stuck_hi), 1);
        cyc(1);
        check("stuck_hi cleared", 32'(bus.stuck_hi), 0);
        cyc(46);
        bus.pwm_in = 1'b0;
        cyc(50);
        repeat (2) drive_period(100, 50);
        cyc(15);
        check("recover valids", 32'(vcount - v0), 2);
        check("recover period", 32'(bus.period_cnt), 100);
        check("recover high", 32'(bus.high_cnt), 50);
        check("recover duty", 32'(bus.duty), 128);

        // Enable dropped mid-divide, then a fresh measurement
        do_reset();
        bus.en = 1'b1;
        repeat (2) drive_period(100, 25);
        bus.pwm_in = 1'b1;
        cyc(6);
        v0 = vcount;
        bus.en = 1'b0;
        cyc(20);
        check("en-drop valids", 32'(vcount - v0), 0);
        check("en-drop period", 32'(bus.period_cnt), 100);
        check("en-drop high", 32'(bus.high_cnt), 25);
        check("en-drop duty", 32'(bus.duty), 64);
        bus.pwm_in = 1'b0;
        cyc(5);
        bus.en = 1'b1;
        v0 = vcount;
        repeat (2) drive_period(40, 30);
        cyc(15);
        check("restart valids", 32'(vcount - v0), 1);
        check("restart period", 32'(bus.period_cnt), 40);
        check("restart high", 32'(bus.high_cnt), 30);
        check("restart duty", 32'(bus.duty), 192);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
